mmio_stepper_responder: RTL

- Memory-mapped responder on the processor data-memory bus (address/data/wren/q) for the plotter.
- Address-decodes a small register window, accepts step commands from the processor and generates step/dir pulse trains for one stepper axis.
- Returns status on reads.
- One instance per axis, placed beside dmem; the top-level muxes q between dmem and responders.

---
 rtl/mmio_stepper_responder_pkg.sv | 28 ++
 rtl/mmio_stepper_responder_if.sv | 24 ++
 rtl/mmio_stepper_responder_step_pulse_timer.sv | 26 ++
 rtl/mmio_stepper_responder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mmio_stepper_responder_pkg.sv
// Shared definitions for the MMIO stepper responder:
// register offsets, STATUS bit positions, FSM states.
package mmio_stepper_responder_pkg;

  localparam logic [1:0] REG_CMD   = 2'd0;
  localparam logic [1:0] REG_HP    = 2'd1;
  localparam logic [1:0] REG_STAT  = 2'd2;
  localparam logic [1:0] REG_ABORT = 2'd3;

  localparam int ST_BUSY    = 0;
  localparam int ST_ERR     = 1;
  localparam int ST_DIR     = 2;
  localparam int ST_REM_LSB = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  // A half period of 0 behaves as 1.
  function automatic logic [15:0] hp_eff(
    input logic [15:0] hp
  );
    return (hp == 16'd0) ? 16'd1 : hp;
  endfunction

endpackage

// File: rtl/mmio_stepper_responder_if.sv
// Processor data-memory bus: address/data/wren in,
// registered read data q out.
interface mmio_stepper_responder_if;

  logic [11:0] address;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q;

  modport master (
    output address,
    output data,
    output wren,
    input  q
  );

  modport slave (
    input  address,
    input  data,
    input  wren,
    output q
  );

endinterface

// File: rtl/mmio_stepper_responder_step_pulse_timer.sv
// Loadable 16-bit down-counter with zero flag.
// Ports: clock, reset(n), load/load_val, dec, zero.
module step_pulse_timer (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        dec,
  output logic        zero
);

  logic [15:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != 16'd0) begin
      count <= count - 16'd1;
    end
  end

  assign zero = (count == 16'd0);

endmodule

// File: rtl/mmio_stepper_responder.sv
// MMIO step/dir generator for one stepper axis.
// Ports: clock, reset(n), bus (slave), step, dir, busy.
module mmio_stepper_responder
  import mmio_stepper_responder_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR         = 12'hF00,
  parameter logic [15:0] RESET_HALF_PERIOD = 16'd1000
) (
  input  logic                      clock,
  input  logic                      reset,
  mmio_stepper_responder_if.slave   bus,
  output logic                      step,
  output logic                      dir,
  output logic                      busy
);

  logic [11:0] off;
  logic        hit;
  logic [1:0]  sel;
  logic        wr_cmd;
  logic        wr_hp;
  logic        wr_st;
  logic        wr_abort;
  logic        rd_hp;
  logic        rd_st;

  state_t      state;
  state_t      state_n;
  logic [15:0] remaining;
  logic [15:0] rem_n;
  logic [15:0] hp;
  logic        dir_n;
  logic        err;
  logic        err_n;
  logic        t_load;
  logic        t_dec;
  logic        t_zero;
  logic [15:0] reload;
  logic [31:0] status;
  logic [31:0] rd_data;
  logic        unused_data;

  assign off = bus.address - BASE_ADDR;
  assign hit = (off[11:2] == 10'd0);
  assign sel = off[1:0];

  assign wr_cmd   = bus.wren & hit & (sel == REG_CMD);
  assign wr_hp    = bus.wren & hit & (sel == REG_HP);
  assign wr_st    = bus.wren & hit & (sel == REG_STAT);
  assign wr_abort = bus.wren & hit & (sel == REG_ABORT);

  // Reads ignore wren.
  assign rd_hp = hit & (sel == REG_HP);
  assign rd_st = hit & (sel == REG_STAT);

  assign busy = (state != S_IDLE);
  assign step = (state == S_HIGH);

  // Sampled at each reload, so HP writes apply there.
  assign reload = hp_eff(hp) - 16'd1;

  assign unused_data = ^bus.data[30:16];

  step_pulse_timer u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (t_load),
    .load_val (reload),
    .dec      (t_dec),
    .zero     (t_zero)
  );

  always_comb begin
    state_n = state;
    rem_n   = remaining;
    dir_n   = dir;
    err_n   = err;
    t_load  = 1'b0;
    t_dec   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (wr_cmd && bus.data[15:0] != 16'd0) begin
          rem_n   = bus.data[15:0];
          dir_n   = bus.data[31];
          t_load  = 1'b1;
          state_n = S_HIGH;
        end
      end
      S_HIGH: begin
        if (t_zero) begin
          state_n = S_LOW;
          t_load  = 1'b1;
        end else begin
          t_dec = 1'b1;
        end
      end
      S_LOW: begin
        if (t_zero) begin
          rem_n = remaining - 16'd1;
          if (remaining == 16'd1) begin
            state_n = S_IDLE;
          end else begin
            state_n = S_HIGH;
            t_load  = 1'b1;
          end
        end else begin
          t_dec = 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    if (wr_cmd && busy) begin
      err_n = 1'b1;
    end
    if (wr_st && bus.data[ST_ERR]) begin
      err_n = 1'b0;
    end
    // Abort wins over everything; dir is kept.
    if (wr_abort) begin
      state_n = S_IDLE;
      rem_n   = '0;
      t_load  = 1'b0;
      t_dec   = 1'b0;
    end
  end

  always_comb begin
    status = '0;
    status[ST_BUSY] = busy;
    status[ST_ERR]  = err;
    status[ST_DIR]  = dir;
    status[ST_REM_LSB +: 16] = remaining;
  end

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      rd_hp:   rd_data = {16'd0, hp};
      rd_st:   rd_data = status;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      remaining <= '0;
      dir       <= 1'b0;
      err       <= 1'b0;
      hp        <= RESET_HALF_PERIOD;
      bus.q     <= '0;
    end else begin
      state     <= state_n;
      remaining <= rem_n;
      dir       <= dir_n;
      err       <= err_n;
      if (wr_hp) begin
        hp <= bus.data[15:0];
      end
      bus.q     <= rd_data;
    end
  end

endmodule
